// File: rtl/count8_ctr.sv
// count8_ctr: WIDTH-bit up-counter with synchronous reset, parallel load and count enable.
// Define COUNT8_CTR_SATURATE_EN to make counting stop at all-ones instead of wrapping.
module count8_ctr #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT,
    output logic             TC
);
    logic             all_ones;
    logic [WIDTH-1:0] cnt_inc;
    assign all_ones = &CNT;
`ifdef COUNT8_CTR_SATURATE_EN
    assign cnt_inc = all_ones ? CNT : CNT + WIDTH'(1);
`else
    assign cnt_inc = CNT + WIDTH'(1);
`endif
    assign TC = all_ones & EN & ~load & ~res;
    always_ff @(posedge clk)
        if (res)       CNT <= RST_VAL;
        else if (load) CNT <= CNT_In;
        else if (EN)   CNT <= cnt_inc;
endmodule

// File: tb/tb_count8_ctr.sv
// tb_count8_ctr: directed and randomized checks of two count8_ctr instances against a reference model.
module tb_count8_ctr;
    logic       clk = 1'b0;
    logic       res = 1'b0, EN = 1'b0, load = 1'b0;
    logic [7:0] CNT_In = '0;
    logic [7:0] cnt_a, cnt_b;
    logic       tc_a, tc_b;
    int         n_checks = 0, n_fail = 0;
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    count8_ctr #(.WIDTH(8), .RST_VAL(8'h00)) dut_a (
        .clk(clk), .res(res), .EN(EN), .load(load), .CNT_In(CNT_In), .CNT(cnt_a), .TC(tc_a)
    );
    count8_ctr #(.WIDTH(8), .RST_VAL(8'h00)) dut_b (
        .clk(clk), .res(res), .EN(EN), .load(load), .CNT_In(CNT_In), .CNT(cnt_b), .TC(tc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle: check TC before the edge, advance the model, check CNT after it.
    task automatic step(input logic r, input logic l, input logic e, input logic [7:0] d);
        res = r; load = l; EN = e; CNT_In = d;
        #1;
        chk("tc_a", {31'd0, tc_a}, {31'd0, (!r && !l && e && exp_cnt == 255)});
        chk("tc_b", {31'd0, tc_b}, {31'd0, (!r && !l && e && exp_cnt == 255)});
        @(posedge clk);
        if (r)      exp_cnt = 0;
        else if (l) exp_cnt = int'(d);
`ifdef COUNT8_CTR_SATURATE_EN
        else if (e) exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
`else
        else if (e) exp_cnt = (exp_cnt + 1) % 256;
`endif
        #1;
        chk("cnt_a", {24'd0, cnt_a}, exp_cnt);
        chk("cnt_b", {24'd0, cnt_b}, exp_cnt);
        chk("cnt_ab", {24'd0, cnt_a}, {24'd0, cnt_b});
    endtask

    initial begin
        // Reset with EN high, then count up
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h00);
        chk("reset_val", {24'd0, cnt_a}, 32'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("count_3", {24'd0, cnt_a}, 32'h03);
        step(0, 0, 1, 8'h00);
        chk("count_4", {24'd0, cnt_a}, 32'h04);
        // Load held for two edges, then count from loaded value
        step(0, 1, 1, 8'h11);
        step(0, 1, 1, 8'h11);
        chk("load_hold", {24'd0, cnt_a}, 32'h11);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("load_inc", {24'd0, cnt_a}, 32'h13);
        step(0, 0, 1, 8'h00);
        // Hold with EN low
        step(0, 0, 0, 8'hAA);
        step(0, 0, 0, 8'hAA);
        step(0, 0, 0, 8'hAA);
        chk("hold", {24'd0, cnt_a}, 32'h14);
        step(0, 0, 1, 8'h00);
        chk("resume", {24'd0, cnt_a}, 32'h15);
        // Terminal count and wrap (or saturate)
        step(0, 1, 0, 8'hFE);
        step(0, 0, 1, 8'h00);
        chk("at_ff", {24'd0, cnt_a}, 32'hFF);
        res = 0; load = 0; EN = 1; #1;
        chk("tc_high", {31'd0, tc_a}, 32'd1);
        step(0, 0, 1, 8'h00);
`ifdef COUNT8_CTR_SATURATE_EN
        chk("saturate", {24'd0, cnt_a}, 32'hFF);
`else
        chk("wrap", {24'd0, cnt_a}, 32'h00);
`endif
        step(0, 0, 1, 8'h00);
        // Reset dominates load and EN
        step(0, 1, 0, 8'h77);
        step(1, 1, 1, 8'h55);
        chk("res_over_load", {24'd0, cnt_a}, 32'h00);
        step(0, 1, 1, 8'h55);
        chk("load_after_res", {24'd0, cnt_a}, 32'h55);
        // Randomized mixed stimulus, both instances against the model
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
